// File: rtl/lstm_fixed_pkg.sv
// Fixed-point format and FSM state encoding shared by the LSTM activation
// units (forward tanh/sigmoid and their backward-gradient companions).
package lstm_fixed_pkg;

  localparam int QN  = 6;
  localparam int QM  = 11;
  localparam int W   = QN + QM + 1;
  localparam int ONE = 1 << QM;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    SCALE  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fx_mul_shift.sv
// Signed W x (W+1) fixed-point multiply: the product is arithmetically shifted
// right by QM (floor) and truncated to W+1 bits.
module fx_mul_shift
  import lstm_fixed_pkg::*;
(
  input  logic signed [W-1:0] a,
  input  logic signed [W:0]   b,
  output logic signed [W:0]   p
);

  logic signed [2*W:0] prod;
  logic                unused_prod_bits;

  // Both operands are sign-extended to the full product width so the low
  // 2W+1 bits hold the exact two's-complement product.
  assign prod = $signed({{(W+1){a[W-1]}}, a}) * $signed({{W{b[W]}}, b});

  // Selecting bits [QM+W:QM] is the >>> QM floor shift followed by truncation.
  assign p = prod[QM+W:QM];

  assign unused_prod_bits = ^{prod[2*W:QM+W+1], prod[QM-1:0]};

endmodule

// File: rtl/tanh_grad.sv
// Backward pass of tanh: grad_out = g * (1 - y^2), with a single multiplier
// shared between the squaring step and the scaling step.
module tanh_grad
  import lstm_fixed_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] grad_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] grad_out,
  output logic                d_clamped
);

  localparam logic signed [W:0] ONE_D = (W+1)'(ONE);

  state_t              state;
  state_t              state_next;
  logic signed [W-1:0] y_r;
  logic signed [W-1:0] g_r;
  logic signed [W:0]   sq_r;
  logic signed [W:0]   d;
  logic signed [W:0]   d_c;
  logic                clamp;
  logic signed [W-1:0] mul_a;
  logic signed [W:0]   mul_b;
  logic signed [W:0]   mul_p;

  // Inputs with |y| > 1 make (1 - y^2) negative; the derivative is forced to 0.
  function automatic logic signed [W:0] clamp_nonneg(input logic signed [W:0] v);
    return v[W] ? '0 : v;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SQUARE;
      SQUARE:  state_next = SCALE;
      SCALE:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign d     = ONE_D - sq_r;
  assign clamp = d[W];
  assign d_c   = clamp_nonneg(d);

  always_comb begin
    mul_a = g_r;
    mul_b = d_c;
    if (state == SQUARE) begin
      mul_a = y_r;
      mul_b = {y_r[W-1], y_r};
    end
  end

  fx_mul_shift u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // Operand capture in IDLE, y^2 in SQUARE, result in SCALE, hold in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_r       <= '0;
      g_r       <= '0;
      sq_r      <= '0;
      grad_out  <= '0;
      d_clamped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y_r <= y_in;
            g_r <= grad_in;
          end
        end
        SQUARE: sq_r <= mul_p;
        SCALE: begin
          grad_out  <= mul_p[W-1:0];
          d_clamped <= clamp;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_grad.sv
// Directed and randomized transactions against tanh_grad with a scoreboard of
// expected gradients, latency, handshake and backpressure checks.
module tb_tanh_grad;
  import lstm_fixed_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] grad_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] grad_out;
  logic                d_clamped;

  typedef struct {
    logic signed [W-1:0] grad;
    logic                clamp;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  tanh_grad dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_in      (y_in),
    .grad_in   (grad_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grad_out  (grad_out),
    .d_clamped (d_clamped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [W-1:0] model_grad(input int y, input int g,
                                                     output logic clamp);
    longint sq, d, p;
    sq = (longint'(y) * longint'(y)) >>> QM;
    d  = longint'(ONE) - sq;
    clamp = (d < 0);
    if (d < 0) d = 0;
    p = (longint'(g) * d) >>> QM;
    return W'(p);
  endfunction

  task automatic txn(input int y, input int g, input int eg, input logic ec,
                     input int hold);
    int                  cyc;
    exp_t                e;
    logic signed [W-1:0] held;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("in_ready_before_accept", 32'(in_ready), 1);
    y_in     = W'(y);
    grad_in  = W'(g);
    in_valid = 1'b1;
    sb.push_back('{W'(eg), ec});
    @(posedge clock); #1;
    in_valid = 1'b0;
    y_in     = '0;
    grad_in  = '0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("latency_edges", cyc, 3);
    e = sb.pop_front();
    check("grad_out", 32'(grad_out), 32'(e.grad));
    check("d_clamped", 32'(d_clamped), 32'(e.clamp));
    check("in_ready_in_done", 32'(in_ready), 0);
    if (hold > 0) begin
      out_ready = 1'b0;
      held      = grad_out;
      in_valid  = 1'b1;
      y_in      = 18'sd512;
      grad_in   = 18'sd999;
      repeat (hold) begin
        @(posedge clock); #1;
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_grad_stable", 32'(grad_out), 32'(held));
        check("bp_in_ready", 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clock); #1;
    check("out_valid_after_done", 32'(out_valid), 0);
    check("in_ready_after_done", 32'(in_ready), 1);
  endtask

  initial begin
    int   yi, gi, eg;
    logic ec;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    y_in      = '0;
    grad_in   = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_grad_out", 32'(grad_out), 0);
    check("rst_d_clamped", 32'(d_clamped), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    txn(0, 2048, 2048, 1'b0, 0);
    txn(1024, 2048, 1536, 1'b0, 0);
    txn(-1024, -4096, -3072, 1'b0, 0);

    // Reset while the transaction sits in SCALE.
    y_in     = 18'sd1024;
    grad_in  = 18'sd2048;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_grad_out", 32'(grad_out), 0);
    check("midrst_d_clamped", 32'(d_clamped), 0);
    repeat (4) begin
      check("midrst_no_out_valid", 32'(out_valid), 0);
      @(posedge clock); #1;
    end

    txn(1024, -1, -1, 1'b0, 0);
    txn(2048, 2048, 0, 1'b0, 0);
    txn(3072, 2048, 0, 1'b1, 0);
    txn(1024, 2048, 1536, 1'b0, 5);
    txn(-512, 4096, 3840, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      yi = int'($urandom_range(0, 6144)) - 3072;
      gi = int'($urandom_range(0, 65535)) - 32768;
      eg = int'(model_grad(yi, gi, ec));
      txn(yi, gi, eg, ec, (i == 3) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
